// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StVerify,
      StDone
   } ccff_state_e;

   function automatic int unsigned words_per_pass(input int unsigned chain_len,
                                                  input int unsigned word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/ccff_serializer.sv
// Word register with occupancy count; serializes MSB-first onto the chain head and
// produces the registered head/enable pair plus the host-side ready.
module ccff_serializer #(
   parameter int unsigned WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              active,
   input  logic              flush,
   input  logic              room,
   input  logic              room_next,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              take_bit,
   output logic              head,
   output logic              shift_en
);

   localparam int unsigned OccW = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] sr_q, sr_d;
   logic [OccW-1:0]   occ_q, occ_d;
   logic              head_q, head_d;
   logic              en_q, en_d;
   logic              accept;
   logic              next_bit;

   // occ_q counts bits still waiting in sr_q; the bit on the head flop is already gone.
   always_comb begin
      bs_ready = active && room && ((occ_q == '0) || ((occ_q == OccW'(1)) && room_next));
      accept   = bs_ready && bs_valid;
      take_bit = active && room && ((occ_q != '0) || accept);
      next_bit = (occ_q != '0) ? sr_q[WORD_W-1] : bs_data[WORD_W-1];
      sr_d     = sr_q;
      occ_d    = occ_q;
      head_d   = head_q;
      en_d     = 1'b0;
      if (take_bit) begin
         head_d = next_bit;
         en_d   = 1'b1;
      end
      if (flush) begin
         occ_d = '0;
      end else if (accept) begin
         if (occ_q == '0) begin
            sr_d  = bs_data << 1;
            occ_d = OccW'(WORD_W - 1);
         end else begin
            sr_d  = bs_data;
            occ_d = OccW'(WORD_W);
         end
      end else if (take_bit) begin
         sr_d  = sr_q << 1;
         occ_d = occ_q - OccW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q   <= '0;
         occ_q  <= '0;
         head_q <= 1'b0;
         en_q   <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         occ_q  <= occ_d;
         head_q <= head_d;
         en_q   <= en_d;
      end
   end

   assign head     = head_q;
   assign shift_en = en_q;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain bitstream loader: FSM, pass bit counter and optional readback
// verify (enabled by CCFF_LOADER_VERIFY_EN).
module ccff_loader
   import ccff_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 8,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  mismatch_cnt
);

   ccff_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             active, room, room_next, flush, take_bit;

   assign active    = (state_q == StLoad) || (state_q == StVerify);
   assign room      = cnt_q < CNT_W'(CHAIN_LEN);
   assign room_next = cnt_q < CNT_W'(CHAIN_LEN - 1);
   // Leftover bits of a partial last word are dropped once the pass is complete.
   assign flush     = !active || !room;

   ccff_serializer #(
      .WORD_W(WORD_W)
   ) u_ser (
      .clk      (prog_clk),
      .rst_n    (prog_rst_n),
      .active   (active),
      .flush    (flush),
      .room     (room),
      .room_next(room_next),
      .bs_data  (bs_data),
      .bs_valid (bs_valid),
      .bs_ready (bs_ready),
      .take_bit (take_bit),
      .head     (ccff_head),
      .shift_en (ccff_shift_en)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               cnt_d   = '0;
            end
         end
         StLoad: begin
            if (!room) begin
`ifdef CCFF_LOADER_VERIFY_EN
               state_d = StVerify;
               cnt_d   = '0;
`else
               state_d = StDone;
`endif
            end else if (take_bit) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StVerify: begin
            if (!room) begin
               state_d = StDone;
            end else if (take_bit) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = active;
   assign done = (state_q == StDone);

`ifdef CCFF_LOADER_VERIFY_EN
   logic             err_q;
   logic [CNT_W-1:0] mm_q;

   // The tail seen during a pass-2 shift is the pre-shift pass-1 bit at the same index.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         err_q <= 1'b0;
         mm_q  <= '0;
      end else if ((state_q == StIdle) && start) begin
         err_q <= 1'b0;
         mm_q  <= '0;
      end else if ((state_q == StVerify) && ccff_shift_en && (ccff_tail != ccff_head)) begin
         err_q <= 1'b1;
         if (mm_q < CNT_W'(CHAIN_LEN)) begin
            mm_q <= mm_q + 1'b1;
         end
      end
   end

   assign err          = err_q;
   assign mismatch_cnt = mm_q;
`else
   logic unused_tail;
   assign unused_tail  = ccff_tail;
   assign err          = 1'b0;
   assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: 8- and 12-bit chains with behavioural chain flops and a bit scoreboard.
`timescale 1ns/1ps
module tb_ccff_loader;
   import ccff_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, bs_valid, sel12;
   logic [7:0] bs_data;

   logic       rdy8, head8, en8, busy8, done8, err8;
   logic [3:0] mm8;
   logic       rdy12, head12, en12, busy12, done12, err12;
   logic [3:0] mm12;
   logic [7:0]  chain8;
   logic [11:0] chain12;

   always @(posedge clk) if (en8) chain8 <= {chain8[6:0], head8};
   always @(posedge clk) if (en12) chain12 <= {chain12[10:0], head12};

   ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_d8 (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .bs_data(bs_data),
      .bs_valid(bs_valid), .bs_ready(rdy8), .ccff_head(head8), .ccff_shift_en(en8),
      .ccff_tail(chain8[7]), .busy(busy8), .done(done8), .err(err8), .mismatch_cnt(mm8)
   );

   ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_d12 (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .bs_data(bs_data),
      .bs_valid(bs_valid), .bs_ready(rdy12), .ccff_head(head12), .ccff_shift_en(en12),
      .ccff_tail(chain12[11]), .busy(busy12), .done(done12), .err(err12), .mismatch_cnt(mm12)
   );

   logic       rdy, head, sh_en, busy, done_s, err;
   logic [3:0] mm;
   assign rdy    = sel12 ? rdy12  : rdy8;
   assign head   = sel12 ? head12 : head8;
   assign sh_en  = sel12 ? en12   : en8;
   assign busy   = sel12 ? busy12 : busy8;
   assign done_s = sel12 ? done12 : done8;
   assign err    = sel12 ? err12  : err8;
   assign mm     = sel12 ? mm12   : mm8;

   typedef struct {
      bit         sel12;
      logic [7:0] w0, w1, v0, v1;
      int         stall, gap, mid_at, exp_done;
      bit         keep;
   } vec_t;

   vec_t tbl[8];
   bit   exp_q[$];
   int   errors = 0, checks = 0;
   int   ticks, shifts, gaps, done_at, mid_at, left, chain, nw;

   function automatic vec_t mk(bit s, logic [7:0] w0, logic [7:0] w1, logic [7:0] v0,
                               logic [7:0] v1, int stall, int gap, int mid, int dn, bit keep);
      vec_t v;
      v.sel12 = s; v.w0 = w0; v.w1 = w1; v.v0 = v0; v.v1 = v1;
      v.stall = stall; v.gap = gap; v.mid_at = mid; v.exp_done = dn; v.keep = keep;
      return v;
   endfunction

   // Mismatches the chain should report: pass-1 vs pass-2 bits within CHAIN_LEN.
   function automatic int model_mm(vec_t v, int len);
      logic [15:0] a, b;
      int n = 0;
      a = {v.w0, v.w1};
      b = {v.v0, v.v1};
      for (int k = 0; k < len; k++) if (a[15-k] != b[15-k]) n++;
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(output logic acc);
      bit e;
      if (ticks == mid_at) start = 1'b1;
      acc = bs_valid && rdy;
      if (acc) begin
         for (int b = 7; b >= 0; b--) begin
            if (left > 0) begin
               exp_q.push_back(bs_data[b]);
               left--;
            end
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      ticks++;
      if (sh_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_shift: shift at tick %0d, expected no shift", ticks);
         end else begin
            e = exp_q.pop_front();
            check("head_bit", head, e);
         end
         shifts++;
      end else if (shifts % chain != 0) begin
         gaps++;
      end
      if (done_s && done_at < 0) begin
         done_at = ticks;
         check("busy_at_done", busy, 0);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, rdy, 0);
      check({tag, "_head"}, head, 0);
      check({tag, "_shift_en"}, sh_en, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done_s, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_mm"}, mm, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      bs_valid = 1'b0;
      bs_data = 8'h00;
      exp_q.delete();
      #1;
      check_reset_vals("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic feed(input logic [7:0] w0, input logic [7:0] w1, input int stall);
      logic acc;
      int   k;
      for (int i = 0; i < nw; i++) begin
         if (i > 0 && stall > 0) begin
            bs_valid = 1'b0;
            for (k = 0; k < 50 && !rdy; k++) tick(acc);
            repeat (stall) tick(acc);
         end
         bs_data  = (i == 0) ? w0 : w1;
         bs_valid = 1'b1;
         acc = 1'b0;
         for (k = 0; k < 50 && !acc; k++) tick(acc);
         if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %0d not accepted, expected accept", i);
         end
      end
   endtask

   task automatic begin_vec(input vec_t v);
      logic acc;
      sel12 = v.sel12;
      chain = v.sel12 ? 12 : 8;
      nw    = int'(words_per_pass(chain, 8));
      if (!v.keep) do_reset();
      ticks = 0; shifts = 0; gaps = 0; done_at = -1; mid_at = v.mid_at; left = chain;
      start = 1'b1;
      tick(acc);
      check("busy_after_start", busy, 1);
      check("ready_after_start", rdy, 1);
   endtask

   task automatic run_vec(input vec_t v);
      logic acc;
      int   mm_exp, passes;
      mm_exp = 0;
      passes = 1;
      begin_vec(v);
      feed(v.w0, v.w1, v.stall);
`ifdef CCFF_LOADER_VERIFY_EN
      left = chain;
      feed(v.v0, v.v1, 0);
      mm_exp = model_mm(v, chain);
      passes = 2;
`endif
      bs_valid = 1'b0;
      for (int k = 0; k < 100 && done_at < 0; k++) tick(acc);
      if (done_at < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done, expected done at %0d", v.exp_done);
      end else begin
         check("done_cycle", done_at, v.exp_done + (passes - 1) * chain);
         check("err_at_done", err, (mm_exp != 0) ? 1 : 0);
         check("mm_at_done", mm, mm_exp);
      end
      check("shift_count", shifts, passes * chain);
      check("stall_gaps", gaps, v.gap);
      check("queue_drained", exp_q.size(), 0);
      tick(acc);
      check("done_one_cycle", done_s, 0);
   endtask

   initial begin
      logic acc;
      rst_n = 1'b0; start = 1'b0; bs_valid = 1'b0; bs_data = 8'h00; sel12 = 1'b0;
      chain = 8; ticks = 0; mid_at = -1; left = 0; shifts = 0; done_at = -1;
      // Stall of 4 held-off ready cycles: the first still drains the last bit, so 3 gaps.
      tbl[0] = mk(0, 8'hA5, 8'h00, 8'hA5, 8'h00, 0, 0, -1, 10, 0);
      tbl[1] = mk(1, 8'hF0, 8'h3C, 8'hF0, 8'h3C, 0, 0, -1, 14, 0);
      tbl[2] = mk(1, 8'hF0, 8'h3C, 8'hF0, 8'h3C, 4, 3, -1, 17, 0);
      tbl[3] = mk(0, 8'hA5, 8'h00, 8'hA4, 8'h00, 0, 0, -1, 10, 0);
      tbl[4] = mk(0, 8'hA5, 8'h00, 8'hA5, 8'h00, 0, 0, -1, 10, 1);
      tbl[5] = mk(0, 8'h3C, 8'h00, 8'h3C, 8'h00, 0, 0,  4, 10, 0);
      tbl[6] = mk(1, 8'h96, 8'hE1, 8'h96, 8'hE1, 0, 0,  6, 14, 0);
      tbl[7] = mk(1, 8'hF0, 8'h3C, 8'hF0, 8'h3D, 0, 0, -1, 14, 0);

      for (int i = 0; i < 8; i++) run_vec(tbl[i]);

      // Reset in the middle of a load, then a full reload.
      begin_vec(tbl[0]);
      bs_data  = 8'hA5;
      bs_valid = 1'b1;
      for (int k = 0; k < 20 && shifts < 3; k++) tick(acc);
      check("pre_reset_shifts", shifts, 3);
      check("pre_reset_head", head, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midload");
      bs_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_vec(tbl[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
